// File: rtl/year_calc_pkg.sv
// Shared types and constants for the sequential year calculator.
// Imported by the top, the divider and the handshake interface users.
package year_calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_e;

  localparam int DIVISOR      = 100;
  localparam int DEFAULT_YEAR = 2019;

endpackage

// File: rtl/year_calc_seq_if.sv
// Valid/ready request and result bundle of year_calc_seq.
// The master side is the front end; the slave side is the calculator.
interface year_calc_seq_if #(
  parameter int K = 13
) ();

  logic         in_valid;
  logic         in_ready;
  logic [K-1:0] year_in;
  logic         use_default;
  logic         out_valid;
  logic         out_ready;
  logic [K-1:0] year_out;
  logic [K:0]   delta;
  logic         fail;
  logic         ok;
  logic         leap;

  modport master (
    output in_valid,
    output year_in,
    output use_default,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  year_out,
    input  delta,
    input  fail,
    input  ok,
    input  leap
  );

  modport slave (
    input  in_valid,
    input  year_in,
    input  use_default,
    input  out_ready,
    output in_ready,
    output out_valid,
    output year_out,
    output delta,
    output fail,
    output ok,
    output leap
  );

endinterface

// File: rtl/year_div100_serial.sv
// Restoring divide-by-100, one quotient bit per clock, MSB first.
// A start loads the dividend; K-1 steps follow, done flags the last.
module year_div100_serial
  import year_calc_pkg::*;
#(
  parameter int K = 13
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [K-2:0] dividend,
  output logic         busy,
  output logic         done,
  output logic [K-2:0] Q,
  output logic [6:0]   R
);

  localparam int CW = $clog2(K);

  logic [K-2:0]  dvd_q, dvd_d;
  logic [K-2:0]  quo_q, quo_d;
  logic [6:0]    rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [7:0] rem_sh;
  logic       ge;
  logic [6:0] rem_nx;

  always_comb begin
    rem_sh = {rem_q, dvd_q[K-2]};
    ge     = rem_sh >= 8'(DIVISOR);
    rem_nx = 7'(ge ? rem_sh - 8'(DIVISOR) : rem_sh);
  end

  always_comb begin
    dvd_d = dvd_q;
    quo_d = quo_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    if (start) begin
      dvd_d = dividend;
      quo_d = '0;
      rem_d = '0;
      cnt_d = CW'(K - 1);
    end else if (busy) begin
      dvd_d = dvd_q << 1;
      quo_d = {quo_q[K-3:0], ge};
      rem_d = rem_nx;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      dvd_q <= dvd_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy = cnt_q != '0;
  assign done = cnt_q == CW'(1);
  assign Q    = quo_q;
  assign R    = rem_q;

endmodule

// File: rtl/year_calc_seq.sv
// Sequential year check: validity, delta to the reference year and
// a Gregorian leap flag derived from a serial divide-by-100.
module year_calc_seq
  import year_calc_pkg::*;
#(
  parameter int K        = 13,
  parameter int REF_YEAR = DEFAULT_YEAR
) (
  input logic          clk,
  input logic          reset,
  year_calc_seq_if.slave bus
);

  state_e state_q, state_d;

  logic [K-1:0] year_q, year_d;
  logic [K:0]   delta_q, delta_d;
  logic         fail_q, fail_d;
  logic         ok_q, ok_d;

  logic [K-1:0] y_sel;
  logic [K:0]   delta_c;
  logic         fail_c;
  logic         ok_c;
  logic         accept;
  logic         div_start;
  logic         div_busy;
  logic         div_done;
  logic [K-2:0] div_q;
  logic [6:0]   div_r;
  logic         unused_q;

  // Sign-extend both operands so the difference cannot overflow.
  always_comb begin
    y_sel   = bus.use_default ? K'(REF_YEAR) : bus.year_in;
    delta_c = {y_sel[K-1], y_sel} - (K+1)'(REF_YEAR);
    fail_c  = y_sel[K-1] | (y_sel == '0);
    ok_c    = y_sel != K'(REF_YEAR);
  end

  assign accept    = (state_q == IDLE) & bus.in_valid;
  assign div_start = accept & ~fail_c;

  always_comb begin
    state_d = state_q;
    year_d  = year_q;
    delta_d = delta_q;
    fail_d  = fail_q;
    ok_d    = ok_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          year_d  = y_sel;
          delta_d = delta_c;
          fail_d  = fail_c;
          ok_d    = ok_c;
          state_d = fail_c ? DONE : DIV;
        end
      end
      DIV: begin
        if (div_done || !div_busy) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      year_q  <= '0;
      delta_q <= '0;
      fail_q  <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      year_q  <= year_d;
      delta_q <= delta_d;
      fail_q  <= fail_d;
      ok_q    <= ok_d;
    end
  end

  year_div100_serial #(
    .K (K)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (y_sel[K-2:0]),
    .busy     (div_busy),
    .done     (div_done),
    .Q        (div_q),
    .R        (div_r)
  );

  // Only the low quotient bits matter for the century rule.
  assign unused_q = ^div_q[K-2:2];

  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.year_out  = year_q;
  assign bus.delta     = delta_q;
  assign bus.fail      = fail_q;
  assign bus.ok        = ok_q;
  assign bus.leap      = (state_q == DONE) & ~fail_q
                       & (year_q[1:0] == 2'b00)
                       & ((div_r != '0) | (div_q[1:0] == 2'b00));

endmodule

// File: tb/tb_year_calc_seq.sv
// Directed bench for year_calc_seq with hand-computed expectations.
// Checks latency, result fields, hold behaviour and mid-divide reset.
module tb_year_calc_seq;

  localparam int K = 13;

  logic clk;
  logic reset;
  int   errs;
  int   total;

  year_calc_seq_if #(.K(K)) bus ();

  year_calc_seq #(
    .K        (K),
    .REF_YEAR (2019)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    total++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input int yr, input bit dflt,
                     input int e_year, input int e_delta,
                     input int e_fail, input int e_ok,
                     input int e_leap, input int e_lat,
                     input int hold);
    int lat;
    lat = 0;
    @(negedge clk);
    chk({tag, ".in_ready"}, bus.in_ready, 1);
    bus.in_valid    = 1'b1;
    bus.year_in     = K'(yr);
    bus.use_default = dflt;
    @(posedge clk);
    #1;
    bus.in_valid    = 1'b0;
    bus.year_in     = '0;
    bus.use_default = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = n + 1;
        break;
      end
      @(posedge clk);
    end
    chk({tag, ".latency"}, lat, e_lat);
    chk({tag, ".year"}, $signed(bus.year_out), e_year);
    chk({tag, ".delta"}, $signed(bus.delta), e_delta);
    chk({tag, ".fail"}, bus.fail, e_fail);
    chk({tag, ".ok"}, bus.ok, e_ok);
    chk({tag, ".leap"}, bus.leap, e_leap);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".hold_rdy"}, bus.in_ready, 0);
      chk({tag, ".hold_out"},
          {bus.out_valid, bus.leap, bus.fail, bus.ok,
           bus.year_out, bus.delta},
          {1'b1, 1'(e_leap), 1'(e_fail), 1'(e_ok),
           K'(e_year), (K+1)'(e_delta)});
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".idle_rdy"}, bus.in_ready, 1);
    chk({tag, ".idle_vld"}, bus.out_valid, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".vld"}, bus.out_valid, 0);
    chk({tag, ".rdy"}, bus.in_ready, 1);
    chk({tag, ".outs"},
        {bus.year_out, bus.delta, bus.fail, bus.ok, bus.leap}, 0);
  endtask

  initial begin
    errs            = 0;
    total           = 0;
    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.year_in     = '0;
    bus.use_default = 1'b0;
    bus.out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_zero("reset");

    run("dflt", 555, 1'b1, 2019, 0, 0, 0, 0, 13, 0);
    run("y2024", 2024, 1'b0, 2024, 5, 0, 1, 1, 13, 0);
    run("y2000", 2000, 1'b0, 2000, -19, 0, 1, 1, 13, 0);
    run("y1900", 1900, 1'b0, 1900, -119, 0, 1, 0, 13, 0);
    run("yneg5", -5, 1'b0, -5, -2024, 1, 1, 0, 1, 0);
    run("y0", 0, 1'b0, 0, -2019, 1, 1, 0, 1, 0);
    run("y1000", 1000, 1'b0, 1000, -1019, 0, 1, 0, 13, 20);

    // Abort a divide part way through.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.year_in  = K'(1600);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("middiv.busy", bus.in_ready, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_zero("middiv");

    run("y1600", 1600, 1'b0, 1600, -419, 0, 1, 1, 13, 0);
    run("ymax", 4095, 1'b0, 4095, 2076, 0, 1, 0, 13, 0);
    run("ymin", -4096, 1'b0, -4096, -6115, 1, 1, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end

endmodule

// File: doc/year_calc_seq.md
# year_calc_seq

Sequential, parametrised successor to the combinational year-check datapath. It accepts a signed year over a valid/ready handshake and can substitute the default year on request. It returns the year together with its validity, its difference from the reference year, and a Gregorian leap-year flag. The leap test uses a serial divide-by-100, so latency is fixed per outcome. The block sits between the year-entry/decoder front end and the status/display logic.

## Interface
- K, 13: year width in bits, signed two's complement; K ≥ 8.
- REF_YEAR, 2019: reference/default year; must fit in K-bit signed.
- clk  in  1: single clock, rising edge.
- reset  in  1: synchronous, active-high; sampled only on clk rising edge.
- in_valid  in  1: year_in/use_default valid.
- in_ready  out  1: block can accept; high only in IDLE.
- year_in  in  K: signed candidate year.
- use_default  in  1: when 1 at accept, year_in is ignored and REF_YEAR is used.
- out_valid  out  1: result valid; held until taken.
- out_ready  in  1: consumer takes result.
- year_out  out  K: accepted year (after default substitution).
- delta  out  K+1: signed year_out − REF_YEAR; computed at K+1 bits, never overflows.
- fail  out  1: year_out ≤ 0.
- ok  out  1: year_out ≠ REF_YEAR.
- leap  out  1: Gregorian leap year; forced 0 when fail=1.

## Operation
- FSM states: IDLE, DIV, DONE.
- IDLE: in_ready=1. On in_valid, the block accepts and latches the year Y (REF_YEAR if use_default). It computes fail, ok and delta from Y and registers them.
  - fail=1 → DONE.
  - fail=0 → load the divider with Y, go to DIV.
- DIV: restoring division of Y (K−1 bit magnitude) by 100, one quotient bit per cycle, MSB first. It runs exactly K−1 cycles, then goes to DONE.
  - Quotient Q is K−1 bits; remainder R is 7 bits.
- leap is computed in DONE: leap = (Y[1:0]==0) and ((R≠0) or (Q[1:0]==0)).
- DONE: out_valid=1. All outputs are stable while out_valid=1 and out_ready=0.
  - out_valid & out_ready → IDLE.
  - in_ready stays 0 in DONE, so no new accept can happen in the same cycle as the handoff.
- in_valid is ignored outside IDLE. Input values are not required to be held after accept.
- Reset (any state, including mid-DIV): state←IDLE, the divider is cleared, and any in-flight result is discarded.
  - Reset values: out_valid=0, year_out=0, delta=0, fail=0, ok=0, leap=0.
  - in_ready=1 from the first cycle after reset.

## Timing
- Accept edge t (in_valid & in_ready sampled high).
- fail=1 path: out_valid high from t+1 (latency 1).
- fail=0 path: DIV occupies cycles t+1 … t+K−1; out_valid high from t+K (K=13 → 13 cycles).
- Throughput: one result per K+1 cycles at best (accept, K−1 divide, DONE handoff).
- Boundary values:
  - Y = −2^(K−1) → fail=1, delta = −2^(K−1) − REF_YEAR, exact in K+1 bits.
  - Y = 2^(K−1)−1 → divides normally (4095 for K=13: Q=40, R=95, leap=0).
- out_ready high before out_valid has no effect. The handoff occurs on the first edge where both are high.

## Structure
- Package year_calc_pkg holds:
  - state enum {IDLE, DIV, DONE};
  - DIVISOR = 100;
  - DEFAULT_YEAR = 2019, used as the REF_YEAR default.
- Sub-module year_div100_serial (parameter K) holds the restoring divider.
  - Ports: clk, reset, start, busy, done, Q, R.
  - The top-level FSM owns the handshake and the compare/subtract logic.
- Comparisons and delta use signed arithmetic sign-extended to K+1 bits.

## Test plan
- use_default=1 (year_in=555) → year_out=2019, delta=0, ok=0, fail=0, leap=0, out_valid at t+13.
- year_in=2024, 2000, 1900 in sequence → leap=1,1,0.
  - delta=5, −19, −119; ok=1 for all.
  - Each result appears 13 cycles after its accept.
- year_in=−5, then 0 → fail=1, leap=0, out_valid at t+1; delta=−2024 and −2019.
- year_in=1000 with out_ready held low 20 cycles after out_valid:
  - outputs stable and in_ready=0 throughout (delta=−1019, leap=0);
  - release → IDLE, in_ready=1 next cycle.
- reset asserted 5 cycles into DIV for year 1600 → next cycle all outputs 0, in_ready=1.
  - Subsequent year 1600 → leap=1, delta=−419.
- year_in=4095 and −4096 → leap=0/fail=0 and fail=1 with delta=−6115, verifying K+1-bit delta.
